regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 8x8 register file between two writeback requesters: A (ALU writeback) and B (load/multi-cycle writeback).
- Round-robin arbitration with a valid/ack handshake. Drives the register file's write-enable, write-address and write-data from registered outputs.
- Holds a per-register busy scoreboard: decode reserves a destination, the committed write clears it, and a combinational hazard flag stalls decode on pending source registers.

Parameters:
DATA_W, 8, width of write data
ADDR_W, 3, register address width; register count = 2**ADDR_W
FIRST_PRIO, 0, requester favoured on the first contention after reset (0 = A, 1 = B)

Ports:
clock  input  1  single clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
req_a  input  1  requester A has a write pending; held until ack_a
reg_a  input  ADDR_W  A destination register
data_a  input  DATA_W  A write data
ack_a  output  1  combinational; A granted this cycle, transfer occurs at the next rising edge
req_b  input  1  requester B has a write pending; held until ack_b
reg_b  input  ADDR_W  B destination register
data_b  input  DATA_W  B write data
ack_b  output  1  combinational; B granted this cycle
rsv_valid  input  1  decode reserves a destination this cycle
rsv_reg  input  ADDR_W  register to reserve
rd1_reg  input  ADDR_W  decode source 1
rd2_reg  input  ADDR_W  decode source 2
hazard  output  1  combinational; a source register is busy
esc_reg  output  1  registered write enable to the register file
reg_escr  output  ADDR_W  registered write address
dado_escr  output  DATA_W  registered write data
busy  output  2**ADDR_W  scoreboard, bit i = register i awaiting writeback

Behaviour:
Reset:
- On reset high, immediately (asynchronous) clear: esc_reg, reg_escr, dado_escr, busy, and the last-grant pointer.
- The pointer clears to favour FIRST_PRIO.
- ack_a, ack_b and hazard are forced low while reset is high.
- Reset mid-transfer drops the pending write; no write reaches the register file.

Arbitration, evaluated every cycle:
- Neither req: no ack.
- Exactly one req: that requester is acked.
- Both req: ack the requester not granted last. Only one ack is high per cycle.
- Pointer updates at the edge where a grant occurs; it is unchanged on idle cycles.
- A requester must hold req, reg and data stable until acked; it may drop req the cycle after ack or present a new write.

Write pipeline:
- Grant in cycle N: at edge N, reg_escr/dado_escr load the winner's reg/data and esc_reg loads 1.
- Exception: if the winner's reg = 0, esc_reg loads 0 (register 0 is read-only); the ack is still given.
- No grant in cycle N: esc_reg loads 0. reg_escr/dado_escr hold their previous values.
- The register file commits at edge N+1. Back-to-back grants give one write per cycle.

Scoreboard:
- Set: rsv_valid with rsv_reg != 0 sets busy[rsv_reg] at the rising edge. A reservation of register 0 is ignored; busy[0] is always 0.
- Clear: busy[reg_escr] clears at the edge where esc_reg = 1, i.e. the same edge the register file commits.
- Set and clear of the same register at the same edge: the set wins, because the new instruction owns the register.
- Reserving an already-busy register leaves it busy. The scoreboard is a single bit with no counting.
- Hazard:
  - hazard = (rd1_reg != 0 and busy[rd1_reg]) or (rd2_reg != 0 and busy[rd2_reg]).
  - No bypass: hazard deasserts the cycle after the commit edge.
- A write to a non-busy register is legal and leaves busy unchanged.

Widths: no arithmetic; all fields pass through unmodified.

Test Plan:
- Reset then single write: req_a=1, reg_a=3, data_a=0x0A. Required: ack_a=1 the same cycle; the next cycle esc_reg=1, reg_escr=3, dado_escr=0x0A; the cycle after, esc_reg=0.
- Contention: req_a and req_b held high with reg_a=2/data 0x11 and reg_b=5/data 0x22, FIRST_PRIO=0. Required: acks A, then B, then A on consecutive cycles; reg_escr sequence 2,5,2; never both acks high.
- Scoreboard hazard: rsv_valid=1, rsv_reg=6, with rd1_reg=6 from the next cycle. Required: busy[6]=1 and hazard=1; after req_b writes reg 6, hazard falls the cycle after esc_reg=1.
- Register 0: rsv_reg=0 gives busy=0x00. req_a to reg 0 with data 0xFF gives ack_a=1 and esc_reg stays 0. rd1_reg=0 never raises hazard.
- Set/clear collision: busy[4]=1, and a write to reg 4 commits at the same edge as rsv_valid/rsv_reg=4. Required: busy[4] remains 1 and hazard stays high for rd2_reg=4.
- Asynchronous reset mid-operation: assert reset between clock edges while esc_reg=1 and busy=0x48. Required: esc_reg=0, busy=0x00 and acks low immediately, with no write on the following edge.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Writeback handshake and register-file write port shared by the two requesters
// and the arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              req_a;
    logic [ADDR_W-1:0] reg_a;
    logic [DATA_W-1:0] data_a;
    logic              ack_a;
    logic              req_b;
    logic [ADDR_W-1:0] reg_b;
    logic [DATA_W-1:0] data_b;
    logic              ack_b;
    logic              esc_reg;
    logic [ADDR_W-1:0] reg_escr;
    logic [DATA_W-1:0] dado_escr;

    // Requester / register-file side
    modport master (
        output req_a, reg_a, data_a, req_b, reg_b, data_b,
        input  ack_a, ack_b, esc_reg, reg_escr, dado_escr
    );

    // Arbiter side
    modport slave (
        input  req_a, reg_a, data_a, req_b, reg_b, data_b,
        output ack_a, ack_b, esc_reg, reg_escr, dado_escr
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port, with a per-register
// busy scoreboard that flags decode hazards on pending source registers.
module regfile_write_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int FIRST_PRIO = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    regfile_write_arbiter_if.slave bus,
    input  logic                   rsv_valid,
    input  logic [ADDR_W-1:0]      rsv_reg,
    input  logic [ADDR_W-1:0]      rd1_reg,
    input  logic [ADDR_W-1:0]      rd2_reg,
    output logic                   hazard,
    output logic [2**ADDR_W-1:0]   busy
);
    localparam int NREG = 2**ADDR_W;

    // last_b set means B won the most recent grant, so A wins the next contention
    logic              last_b;
    logic              grant;
    logic [ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0] win_data;
    logic [NREG-1:0]   busy_next;

    always_comb begin
        bus.ack_a = 1'b0;
        bus.ack_b = 1'b0;
        if (!reset) begin
            bus.ack_a = bus.req_a && (!bus.req_b || last_b);
            bus.ack_b = bus.req_b && (!bus.req_a || !last_b);
        end
        grant    = bus.ack_a || bus.ack_b;
        win_reg  = bus.ack_b ? bus.reg_b  : bus.reg_a;
        win_data = bus.ack_b ? bus.data_b : bus.data_a;
    end

    // A reservation landing on the commit edge of the same register wins
    always_comb begin
        busy_next = busy;
        if (bus.esc_reg)
            busy_next[bus.reg_escr] = 1'b0;
        if (rsv_valid && (rsv_reg != '0))
            busy_next[rsv_reg] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        hazard = 1'b0;
        if (!reset)
            hazard = ((rd1_reg != '0) && busy[rd1_reg]) ||
                     ((rd2_reg != '0) && busy[rd2_reg]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.esc_reg   <= 1'b0;
            bus.reg_escr  <= '0;
            bus.dado_escr <= '0;
            busy          <= '0;
            last_b        <= (FIRST_PRIO == 0);
        end else begin
            busy <= busy_next;
            if (grant) begin
                bus.reg_escr  <= win_reg;
                bus.dado_escr <= win_data;
                bus.esc_reg   <= (win_reg != '0);
                last_b        <= bus.ack_b;
            end else begin
                bus.esc_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a cycle-level reference model of the arbiter and scoreboard.
module tb_regfile_write_arbiter;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic       clock;
    logic       reset;
    logic       rsv_valid;
    logic [2:0] rsv_reg;
    logic [2:0] rd1_reg;
    logic [2:0] rd2_reg;
    logic       hazard;
    logic [7:0] busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         m_last_winner;
    logic       m_esc;
    logic [2:0] m_reg;
    logic [7:0] m_data;
    bit   [7:0] m_busy;
    logic       obs_ack_a;
    logic       obs_ack_b;
    logic       exp_ack_a_last;
    logic       exp_ack_b_last;
    logic [1:0] win_seq [3];

    regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIRST_PRIO(0)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .rd1_reg   (rd1_reg),
        .rd2_reg   (rd2_reg),
        .hazard    (hazard),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_last_winner  = 1;
        m_esc          = 1'b0;
        m_reg          = '0;
        m_data         = '0;
        m_busy         = '0;
        exp_ack_a_last = 1'b0;
        exp_ack_b_last = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.req_a  = 1'b0;
        bus.reg_a  = '0;
        bus.data_a = '0;
        bus.req_b  = 1'b0;
        bus.reg_b  = '0;
        bus.data_b = '0;
        rsv_valid  = 1'b0;
        rsv_reg    = '0;
        rd1_reg    = '0;
        rd2_reg    = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: check all outputs at the falling edge, then advance the model
    task automatic apply_stimulus();
        logic       ea;
        logic       eb;
        logic       eh;
        bit   [7:0] nb;
        @(negedge clock);
        if (bus.req_a && bus.req_b) begin
            ea = (m_last_winner == 1);
            eb = !ea;
        end else begin
            ea = bus.req_a;
            eb = bus.req_b;
        end
        eh = ((rd1_reg != 0) && m_busy[rd1_reg]) || ((rd2_reg != 0) && m_busy[rd2_reg]);
        obs_ack_a = bus.ack_a;
        obs_ack_b = bus.ack_b;
        check_output("ack_a", {31'b0, bus.ack_a}, {31'b0, ea});
        check_output("ack_b", {31'b0, bus.ack_b}, {31'b0, eb});
        check_output("one_ack", {31'b0, bus.ack_a & bus.ack_b}, 32'd0);
        check_output("hazard", {31'b0, hazard}, {31'b0, eh});
        check_output("esc_reg", {31'b0, bus.esc_reg}, {31'b0, m_esc});
        check_output("reg_escr", {29'b0, bus.reg_escr}, {29'b0, m_reg});
        check_output("dado_escr", {24'b0, bus.dado_escr}, {24'b0, m_data});
        check_output("busy", {24'b0, busy}, {24'b0, m_busy});

        nb = m_busy;
        if (m_esc)
            nb[m_reg] = 1'b0;
        if (rsv_valid && rsv_reg != 0)
            nb[rsv_reg] = 1'b1;
        if (ea) begin
            m_reg = bus.reg_a; m_data = bus.data_a; m_esc = (bus.reg_a != 0); m_last_winner = 0;
        end else if (eb) begin
            m_reg = bus.reg_b; m_data = bus.data_b; m_esc = (bus.reg_b != 0); m_last_winner = 1;
        end else begin
            m_esc = 1'b0;
        end
        m_busy = nb;
        exp_ack_a_last = ea;
        exp_ack_b_last = eb;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        #2;
        check_output("rst_ack_a", {31'b0, bus.ack_a}, 32'd0);
        check_output("rst_ack_b", {31'b0, bus.ack_b}, 32'd0);
        check_output("rst_esc", {31'b0, bus.esc_reg}, 32'd0);
        check_output("rst_busy", {24'b0, busy}, 32'd0);
        @(posedge clock);
        #1;
        clear_inputs();
        reset = 1'b0;
        model_reset();

        // Single write from A
        bus.req_a = 1'b1; bus.reg_a = 3'd3; bus.data_a = 8'h0A;
        apply_stimulus();
        check_output("t1_ack", {31'b0, obs_ack_a}, 32'd1);
        bus.req_a = 1'b0;
        check_output("t1_esc", {31'b0, bus.esc_reg}, 32'd1);
        check_output("t1_reg", {29'b0, bus.reg_escr}, 32'd3);
        check_output("t1_data", {24'b0, bus.dado_escr}, 32'h0A);
        apply_stimulus();
        check_output("t1_esc_off", {31'b0, bus.esc_reg}, 32'd0);

        // Contention from a fresh pointer: A, B, A
        reset_dut();
        bus.req_a = 1'b1; bus.reg_a = 3'd2; bus.data_a = 8'h11;
        bus.req_b = 1'b1; bus.reg_b = 3'd5; bus.data_b = 8'h22;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            win_seq[i] = {obs_ack_b, obs_ack_a};
            check_output("cont_reg", {29'b0, bus.reg_escr}, (i == 1) ? 32'd5 : 32'd2);
        end
        check_output("cont_win0", {30'b0, win_seq[0]}, 32'd1);
        check_output("cont_win1", {30'b0, win_seq[1]}, 32'd2);
        check_output("cont_win2", {30'b0, win_seq[2]}, 32'd1);
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        apply_stimulus();

        // Reserve r6, hazard until B's write to r6 commits
        rsv_valid = 1'b1; rsv_reg = 3'd6;
        apply_stimulus();
        rsv_valid = 1'b0; rd1_reg = 3'd6;
        check_output("sb_busy6", {31'b0, busy[6]}, 32'd1);
        apply_stimulus();
        bus.req_b = 1'b1; bus.reg_b = 3'd6; bus.data_b = 8'h33;
        apply_stimulus();
        bus.req_b = 1'b0;
        check_output("sb_haz_pend", {31'b0, hazard}, 32'd1);
        apply_stimulus();
        check_output("sb_haz_clr", {31'b0, hazard}, 32'd0);
        rd1_reg = 3'd0;

        // Register 0 is read-only and never busy
        rsv_valid = 1'b1; rsv_reg = 3'd0;
        apply_stimulus();
        rsv_valid = 1'b0;
        check_output("r0_busy", {24'b0, busy}, 32'd0);
        bus.req_a = 1'b1; bus.reg_a = 3'd0; bus.data_a = 8'hFF;
        apply_stimulus();
        bus.req_a = 1'b0;
        check_output("r0_ack", {31'b0, obs_ack_a}, 32'd1);
        check_output("r0_esc", {31'b0, bus.esc_reg}, 32'd0);
        apply_stimulus();

        // Commit and reservation of r4 on the same edge
        rsv_valid = 1'b1; rsv_reg = 3'd4;
        apply_stimulus();
        rsv_valid = 1'b0;
        bus.req_a = 1'b1; bus.reg_a = 3'd4; bus.data_a = 8'h44;
        apply_stimulus();
        bus.req_a = 1'b0;
        rsv_valid = 1'b1; rsv_reg = 3'd4; rd2_reg = 3'd4;
        apply_stimulus();
        rsv_valid = 1'b0;
        check_output("col_busy4", {31'b0, busy[4]}, 32'd1);
        check_output("col_haz", {31'b0, hazard}, 32'd1);
        apply_stimulus();

        // Asynchronous reset with a write in flight and busy = 0x48
        reset_dut();
        rsv_valid = 1'b1; rsv_reg = 3'd3;
        apply_stimulus();
        rsv_reg = 3'd6;
        bus.req_b = 1'b1; bus.reg_b = 3'd1; bus.data_b = 8'h5A;
        apply_stimulus();
        rsv_valid = 1'b0; bus.req_b = 1'b0;
        bus.req_a = 1'b1; bus.reg_a = 3'd2; bus.data_a = 8'h77; rd1_reg = 3'd6;
        check_output("ar_esc_pre", {31'b0, bus.esc_reg}, 32'd1);
        check_output("ar_busy_pre", {24'b0, busy}, 32'h48);
        #2;
        reset = 1'b1;
        #1;
        check_output("ar_esc", {31'b0, bus.esc_reg}, 32'd0);
        check_output("ar_busy", {24'b0, busy}, 32'd0);
        check_output("ar_ack_a", {31'b0, bus.ack_a}, 32'd0);
        check_output("ar_hazard", {31'b0, hazard}, 32'd0);
        @(posedge clock);
        #1;
        check_output("ar_no_write", {31'b0, bus.esc_reg}, 32'd0);
        reset = 1'b0;
        clear_inputs();
        model_reset();

        // Randomized traffic honouring the hold-until-ack rule
        for (int n = 0; n < 400; n++) begin
            if (!bus.req_a || exp_ack_a_last) begin
                bus.req_a = ($urandom_range(0, 2) != 0);
                bus.reg_a = 3'($urandom_range(0, 7));
                bus.data_a = 8'($urandom);
            end
            if (!bus.req_b || exp_ack_b_last) begin
                bus.req_b = ($urandom_range(0, 2) != 0);
                bus.reg_b = 3'($urandom_range(0, 7));
                bus.data_b = 8'($urandom);
            end
            rsv_valid = ($urandom_range(0, 1) != 0);
            rsv_reg = 3'($urandom_range(0, 7));
            rd1_reg = 3'($urandom_range(0, 7));
            rd2_reg = 3'($urandom_range(0, 7));
            apply_stimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
